// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with PC register, write scoreboard and dual-write conflict flag
module regfile_mp #(
    parameter int WIDTH   = 16,
    parameter int AW      = 3,
    parameter int PC_IDX  = (1 << AW) - 1,
    parameter int ZERO_R0 = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we0,
    input  logic [AW-1:0]         waddr0,
    input  logic [WIDTH-1:0]      wdata0,
    input  logic                  we1,
    input  logic [AW-1:0]         waddr1,
    input  logic [WIDTH-1:0]      wdata1,
    input  logic [AW-1:0]         raddr0,
    input  logic [AW-1:0]         raddr1,
    output logic [WIDTH-1:0]      rdata0,
    output logic [WIDTH-1:0]      rdata1,
    input  logic                  pc_inc,
    output logic [WIDTH-1:0]      pcout,
    input  logic                  issue,
    input  logic [AW-1:0]         issue_addr,
    output logic [(1 << AW)-1:0]  busy,
    output logic                  wr_conflict
);

    localparam int NREGS = 1 << AW;
    localparam bit ZR    = (ZERO_R0 != 0);

    logic [WIDTH-1:0] regs [NREGS];
    logic             we0_ok;
    logic             we1_ok;
    logic             issue_ok;

    // Register 0 is hardwired when ZR is set, so strobes aimed at it are dropped here.
    assign we0_ok   = we0 && !(ZR && (waddr0 == '0));
    assign we1_ok   = we1 && !(ZR && (waddr1 == '0));
    assign issue_ok = issue && !(ZR && (issue_addr == '0));

    assign pcout = regs[PC_IDX];

    // Storage update: port 1 beats port 0, any write to the PC beats pc_inc.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (rst || (ZR && i == 0)) begin
                regs[i] <= '0;
            end else if (we1_ok && waddr1 == AW'(i)) begin
                regs[i] <= wdata1;
            end else if (we0_ok && waddr0 == AW'(i)) begin
                regs[i] <= wdata0;
            end else if (i == PC_IDX && pc_inc) begin
                regs[i] <= regs[i] + WIDTH'(1);
            end
        end
    end

    // Scoreboard: issue sets, writeback clears, a same-cycle issue wins over the writeback.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (rst) begin
                busy[i] <= 1'b0;
            end else if (issue_ok && issue_addr == AW'(i)) begin
                busy[i] <= 1'b1;
            end else if ((we0_ok && waddr0 == AW'(i)) || (we1_ok && waddr1 == AW'(i))) begin
                busy[i] <= 1'b0;
            end
        end
    end

    // One-cycle pulse after both ports targeted the same address.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_conflict <= 1'b0;
        end else begin
            wr_conflict <= we0 && we1 && (waddr0 == waddr1);
        end
    end

    // Read port 0 with write-through bypass, disabled during reset.
    always_comb begin
        rdata0 = regs[raddr0];
        if (!rst && we0_ok && waddr0 == raddr0) rdata0 = wdata0;
        if (!rst && we1_ok && waddr1 == raddr0) rdata0 = wdata1;
        if (ZR && raddr0 == '0) rdata0 = '0;
    end

    // Read port 1 with write-through bypass, disabled during reset.
    always_comb begin
        rdata1 = regs[raddr1];
        if (!rst && we0_ok && waddr0 == raddr1) rdata1 = wdata0;
        if (!rst && we1_ok && waddr1 == raddr1) rdata1 = wdata1;
        if (ZR && raddr1 == '0) rdata1 = '0;
    end

endmodule
